// File: rtl/timer_csr_master.sv
// timer_csr_master: host command stream to tick-timer CSR strobes, with optional
// autonomous interrupt acknowledge (read CONTROL, write back with IP cleared).
module timer_csr_master #(
   parameter bit          AUTO_ACK    = 1'b1,
   parameter int unsigned ACK_HOLDOFF = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_write_i,
   input  logic [1:0]  cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        csr_re_o,
   output logic        csr_we_o,
   output logic [1:0]  csr_addr_o,
   output logic [31:0] csr_wdata_o,
   input  logic [31:0] csr_rdata_i,
   input  logic        intr_i,
   output logic [31:0] tick_cnt_o,
   output logic        tick_pulse_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_RSP,
      S_IRD,
      S_IWR
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_holdoff, w_holdoff_nxt;
   logic        r_csr_re, w_csr_re_nxt;
   logic        r_csr_we, w_csr_we_nxt;
   logic [1:0]  r_csr_addr, w_csr_addr_nxt;
   logic [31:0] r_csr_wdata, w_csr_wdata_nxt;
   logic        r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic [31:0] r_tick_cnt, w_tick_cnt_nxt;
   logic        r_tick_pulse, w_tick_pulse_nxt;
   logic        w_irq_take;

   assign w_irq_take   = AUTO_ACK && intr_i && (r_holdoff == 8'd0);
   assign cmd_ready_o  = (r_state == S_IDLE) && !w_irq_take;
   assign busy_o       = (r_state != S_IDLE);
   assign csr_re_o     = r_csr_re;
   assign csr_we_o     = r_csr_we;
   assign csr_addr_o   = r_csr_addr;
   assign csr_wdata_o  = r_csr_wdata;
   assign rsp_valid_o  = r_rsp_valid;
   assign rsp_rdata_o  = r_rsp_rdata;
   assign tick_cnt_o   = r_tick_cnt;
   assign tick_pulse_o = r_tick_pulse;

   // State and registered-output update
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_holdoff    <= '0;
         r_csr_re     <= 1'b0;
         r_csr_we     <= 1'b0;
         r_csr_addr   <= '0;
         r_csr_wdata  <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_rdata  <= '0;
         r_tick_cnt   <= '0;
         r_tick_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_holdoff    <= w_holdoff_nxt;
         r_csr_re     <= w_csr_re_nxt;
         r_csr_we     <= w_csr_we_nxt;
         r_csr_addr   <= w_csr_addr_nxt;
         r_csr_wdata  <= w_csr_wdata_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_rdata  <= w_rsp_rdata_nxt;
         r_tick_cnt   <= w_tick_cnt_nxt;
         r_tick_pulse <= w_tick_pulse_nxt;
      end
   end

   // Next-state and next registered-output values
   always_comb begin
      w_state_nxt      = r_state;
      w_holdoff_nxt    = (r_holdoff != 8'd0) ? r_holdoff - 8'd1 : 8'd0;
      w_csr_re_nxt     = 1'b0;
      w_csr_we_nxt     = 1'b0;
      w_csr_addr_nxt   = r_csr_addr;
      w_csr_wdata_nxt  = r_csr_wdata;
      w_rsp_valid_nxt  = r_rsp_valid;
      w_rsp_rdata_nxt  = r_rsp_rdata;
      w_tick_cnt_nxt   = r_tick_cnt;
      w_tick_pulse_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_irq_take) begin
               w_state_nxt    = S_IRD;
               w_csr_re_nxt   = 1'b1;
               w_csr_addr_nxt = 2'b00;
            end else if (cmd_valid_i) begin
               w_state_nxt     = S_CMD;
               w_csr_re_nxt    = !cmd_write_i;
               w_csr_we_nxt    = cmd_write_i;
               w_csr_addr_nxt  = cmd_addr_i;
               w_csr_wdata_nxt = cmd_write_i ? cmd_wdata_i : '0;
            end
         end
         S_CMD: begin
            w_rsp_rdata_nxt = r_csr_re ? csr_rdata_i : '0;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RSP;
         end
         S_RSP: begin
            if (rsp_ready_i) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         S_IRD: begin
            // the write-data register doubles as ctrl_q: IE/mode kept, IP forced to 0
            w_csr_we_nxt    = 1'b1;
            w_csr_addr_nxt  = 2'b00;
            w_csr_wdata_nxt = {28'h0, 1'b0, csr_rdata_i[2:0]};
            w_state_nxt     = S_IWR;
         end
         S_IWR: begin
            w_tick_cnt_nxt   = r_tick_cnt + 32'd1;
            w_tick_pulse_nxt = 1'b1;
            w_holdoff_nxt    = 8'(ACK_HOLDOFF);
            w_state_nxt      = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule
